// File: rtl/csad_sequencer_if.sv
// csad_sequencer_if: bus between the sequencer, the incrementer/control store and the datapath
interface csad_sequencer_if #(
  parameter int Direction_BUS_WIDTH = 11
);
  logic [Direction_BUS_WIDTH-1:0] CSAD_Direccion_INC_IN;
  logic [Direction_BUS_WIDTH-1:0] CSAD_Direccion_JMP_IN;
  logic [2:0] CSAD_Op_IN;
  logic CSAD_Cond_IN;
  logic CSAD_Stall_IN;
  logic [Direction_BUS_WIDTH-1:0] CSAD_Direccion_OUT;
  logic CSAD_StackFull_OUT;
  logic CSAD_StackEmpty_OUT;
  logic CSAD_Error_OUT;
  modport master (
    output CSAD_Direccion_INC_IN, CSAD_Direccion_JMP_IN, CSAD_Op_IN, CSAD_Cond_IN, CSAD_Stall_IN,
    input CSAD_Direccion_OUT, CSAD_StackFull_OUT, CSAD_StackEmpty_OUT, CSAD_Error_OUT
  );
  modport slave (
    input CSAD_Direccion_INC_IN, CSAD_Direccion_JMP_IN, CSAD_Op_IN, CSAD_Cond_IN, CSAD_Stall_IN,
    output CSAD_Direccion_OUT, CSAD_StackFull_OUT, CSAD_StackEmpty_OUT, CSAD_Error_OUT
  );
endinterface

// File: rtl/csad_sequencer.sv
// csad_sequencer: microprogram address sequencer with a return-address stack
module csad_sequencer #(
  parameter int Direction_BUS_WIDTH = 11,
  parameter int STACK_DEPTH = 4
) (
  input logic CSAD_CLOCK_50,
  input logic CSAD_RESET_InHigh,
  csad_sequencer_if.slave bus
);
  localparam int W = Direction_BUS_WIDTH;
  localparam int SPW = $clog2(STACK_DEPTH) + 1;
  localparam int IW = SPW - 1;
  typedef enum logic [2:0] {
    OP_NEXT, OP_JUMP, OP_BRT, OP_BRF, OP_CALL, OP_RET, OP_RESTART, OP_HOLD
  } op_e;
  logic [W-1:0] addr_q, addr_d, inc, jmp;
  logic [W-1:0] stack_q [STACK_DEPTH];
  logic [W-1:0] stack_d [STACK_DEPTH];
  logic [SPW-1:0] sp_q, sp_d, sp_m1;
  logic err_q, err_d, full, empty, cond;
  op_e op;
  assign inc = bus.CSAD_Direccion_INC_IN;
  assign jmp = bus.CSAD_Direccion_JMP_IN;
  assign cond = bus.CSAD_Cond_IN;
  assign op = op_e'(bus.CSAD_Op_IN);
  assign full = sp_q == SPW'(STACK_DEPTH);
  assign empty = sp_q == '0;
  assign sp_m1 = sp_q - SPW'(1);
  // Full CALL and empty RET fall through to INC so the stack is never corrupted
  always_comb begin
    addr_d = addr_q;
    sp_d = sp_q;
    stack_d = stack_q;
    err_d = err_q;
    if (!bus.CSAD_Stall_IN)
      case (op)
        OP_NEXT: addr_d = inc;
        OP_JUMP: addr_d = jmp;
        OP_BRT: addr_d = cond ? jmp : inc;
        OP_BRF: addr_d = cond ? inc : jmp;
        OP_CALL: begin
          addr_d = full ? inc : jmp;
          err_d = err_q | full;
          if (!full) begin
            stack_d[sp_q[IW-1:0]] = inc;
            sp_d = sp_q + SPW'(1);
          end
        end
        OP_RET: begin
          addr_d = empty ? inc : stack_q[sp_m1[IW-1:0]];
          sp_d = empty ? sp_q : sp_m1;
          err_d = err_q | empty;
        end
        OP_RESTART: begin
          addr_d = '0;
          sp_d = '0;
        end
        default: ;
      endcase
  end
  always_ff @(posedge CSAD_CLOCK_50 or posedge CSAD_RESET_InHigh)
    if (CSAD_RESET_InHigh) begin
      addr_q <= '0;
      sp_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      addr_q <= addr_d;
      sp_q <= sp_d;
      err_q <= err_d;
      stack_q <= stack_d;
    end
  assign bus.CSAD_Direccion_OUT = addr_q;
  assign bus.CSAD_StackFull_OUT = full;
  assign bus.CSAD_StackEmpty_OUT = empty;
  assign bus.CSAD_Error_OUT = err_q;
endmodule

// File: tb/tb_csad_sequencer.sv
// tb_csad_sequencer: directed-vector bench for the microprogram sequencer
module tb_csad_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  csad_sequencer_if #(.Direction_BUS_WIDTH(11)) bus ();
  csad_sequencer #(.Direction_BUS_WIDTH(11), .STACK_DEPTH(4)) dut (
    .CSAD_CLOCK_50(clk),
    .CSAD_RESET_InHigh(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [2:0] op, input logic [10:0] inc, input logic [10:0] jmp,
                      input logic cond, input logic stall);
    bus.CSAD_Op_IN = op;
    bus.CSAD_Direccion_INC_IN = inc;
    bus.CSAD_Direccion_JMP_IN = jmp;
    bus.CSAD_Cond_IN = cond;
    bus.CSAD_Stall_IN = stall;
    @(posedge clk);
    #1;
  endtask
  task automatic flags(input string tag, input logic [10:0] a, input logic f, input logic e, input logic r);
    chk({tag, "_addr"}, 32'(bus.CSAD_Direccion_OUT), 32'(a));
    chk({tag, "_full"}, 32'(bus.CSAD_StackFull_OUT), 32'(f));
    chk({tag, "_empty"}, 32'(bus.CSAD_StackEmpty_OUT), 32'(e));
    chk({tag, "_err"}, 32'(bus.CSAD_Error_OUT), 32'(r));
  endtask
  initial begin
    bus.CSAD_Op_IN = 3'b000;
    bus.CSAD_Direccion_INC_IN = '0;
    bus.CSAD_Direccion_JMP_IN = '0;
    bus.CSAD_Cond_IN = 1'b0;
    bus.CSAD_Stall_IN = 1'b0;
    #1;
    flags("reset", 11'h000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(3'b000, 11'h001, 11'h3FF, 1'b0, 1'b0); chk("next1", 32'(bus.CSAD_Direccion_OUT), 32'h001);
    step(3'b000, 11'h002, 11'h3FF, 1'b0, 1'b0); chk("next2", 32'(bus.CSAD_Direccion_OUT), 32'h002);
    step(3'b000, 11'h7FF, 11'h3FF, 1'b0, 1'b0); chk("next3", 32'(bus.CSAD_Direccion_OUT), 32'h7FF);
    step(3'b000, 11'h000, 11'h3FF, 1'b0, 1'b0); chk("next_wrap", 32'(bus.CSAD_Direccion_OUT), 32'h000);
    step(3'b010, 11'h005, 11'h040, 1'b1, 1'b0); chk("brt_t", 32'(bus.CSAD_Direccion_OUT), 32'h040);
    step(3'b010, 11'h041, 11'h300, 1'b0, 1'b0); chk("brt_f", 32'(bus.CSAD_Direccion_OUT), 32'h041);
    step(3'b011, 11'h041, 11'h200, 1'b1, 1'b0); chk("brf_t", 32'(bus.CSAD_Direccion_OUT), 32'h041);
    step(3'b011, 11'h042, 11'h100, 1'b0, 1'b0); chk("brf_f", 32'(bus.CSAD_Direccion_OUT), 32'h100);
    step(3'b001, 11'h101, 11'h123, 1'b0, 1'b0); chk("jump", 32'(bus.CSAD_Direccion_OUT), 32'h123);
    step(3'b100, 11'h011, 11'h100, 1'b0, 1'b0); flags("call1", 11'h100, 1'b0, 1'b0, 1'b0);
    step(3'b100, 11'h101, 11'h200, 1'b0, 1'b0); flags("call2", 11'h200, 1'b0, 1'b0, 1'b0);
    step(3'b100, 11'h201, 11'h300, 1'b0, 1'b0); flags("call3", 11'h300, 1'b0, 1'b0, 1'b0);
    step(3'b100, 11'h301, 11'h400, 1'b0, 1'b0); flags("call4", 11'h400, 1'b1, 1'b0, 1'b0);
    step(3'b100, 11'h401, 11'h500, 1'b0, 1'b0); flags("call5_ovf", 11'h401, 1'b1, 1'b0, 1'b1);
    step(3'b101, 11'h402, 11'h000, 1'b0, 1'b0); flags("ret1", 11'h301, 1'b0, 1'b0, 1'b1);
    step(3'b101, 11'h302, 11'h000, 1'b0, 1'b0); flags("ret2", 11'h201, 1'b0, 1'b0, 1'b1);
    step(3'b101, 11'h202, 11'h000, 1'b0, 1'b0); flags("ret3", 11'h101, 1'b0, 1'b0, 1'b1);
    step(3'b101, 11'h102, 11'h000, 1'b0, 1'b0); flags("ret4", 11'h011, 1'b0, 1'b1, 1'b1);
    rst = 1'b1; #1; rst = 1'b0;
    flags("rst_clr", 11'h000, 1'b0, 1'b1, 1'b0);
    step(3'b101, 11'h022, 11'h0EE, 1'b0, 1'b0); flags("ret_unf", 11'h022, 1'b0, 1'b1, 1'b1);
    step(3'b000, 11'h023, 11'h0EE, 1'b0, 1'b0); flags("err_next", 11'h023, 1'b0, 1'b1, 1'b1);
    step(3'b110, 11'h024, 11'h0EE, 1'b0, 1'b0); flags("err_restart", 11'h000, 1'b0, 1'b1, 1'b1);
    rst = 1'b1; #1; rst = 1'b0;
    chk("err_reset", 32'(bus.CSAD_Error_OUT), 32'h0);
    step(3'b001, 11'h001, 11'h0AA, 1'b0, 1'b0); chk("pre_stall", 32'(bus.CSAD_Direccion_OUT), 32'h0AA);
    for (int i = 0; i < 3; i++) begin
      step(3'b100, 11'h055, 11'h0CC, 1'b0, 1'b1);
      flags($sformatf("stall%0d", i), 11'h0AA, 1'b0, 1'b1, 1'b0);
    end
    step(3'b100, 11'h055, 11'h0CC, 1'b0, 1'b0); flags("stall_call", 11'h0CC, 1'b0, 1'b0, 1'b0);
    step(3'b111, 11'h0CD, 11'h0DD, 1'b1, 1'b0); flags("hold", 11'h0CC, 1'b0, 1'b0, 1'b0);
    step(3'b101, 11'h0CE, 11'h0DD, 1'b0, 1'b0); flags("stall_ret", 11'h055, 1'b0, 1'b1, 1'b0);
    step(3'b100, 11'h066, 11'h0E0, 1'b0, 1'b0); chk("b2b_call", 32'(bus.CSAD_Direccion_OUT), 32'h0E0);
    step(3'b101, 11'h0E1, 11'h000, 1'b0, 1'b0); flags("b2b_ret", 11'h066, 1'b0, 1'b1, 1'b0);
    step(3'b101, 11'h067, 11'h000, 1'b0, 1'b1); flags("stall_ret_empty", 11'h066, 1'b0, 1'b1, 1'b0);
    step(3'b100, 11'h001, 11'h010, 1'b0, 1'b0);
    step(3'b100, 11'h011, 11'h155, 1'b0, 1'b0); flags("pre_rst", 11'h155, 1'b0, 1'b0, 1'b0);
    bus.CSAD_Op_IN = 3'b100;
    bus.CSAD_Stall_IN = 1'b1;
    #2 rst = 1'b1;
    #1 flags("async_rst", 11'h000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    flags("rst_held", 11'h000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(3'b101, 11'h033, 11'h000, 1'b0, 1'b0); flags("post_rst_ret", 11'h033, 1'b0, 1'b1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csad_sequencer.md
# csad_sequencer

Microprogram address sequencer for the micro-datapath. It holds the current control-store address and drives it to the control store and to the next-address incrementer. Each cycle it selects the next address from the incrementer result, a jump target from the microinstruction, or a 4-deep return-address stack. It is the stage directly upstream of the incrementer and consumes the incrementer's output on the following cycle.

## Interface
Parameters:
- Direction_BUS_WIDTH, 11, micro-address width.
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2).

Ports (name, direction, width, meaning):
- CSAD_CLOCK_50, in, 1, system clock; all state updates on rising edge.
- CSAD_RESET_InHigh, in, 1, asynchronous, active-high reset.
- CSAD_Direccion_INC_IN, in, W, incremented address from the incrementer (current address + 1, mod 2^W).
- CSAD_Direccion_JMP_IN, in, W, jump/call target field of the current microinstruction.
- CSAD_Op_IN, in, 3, sequencing operation (see Operation).
- CSAD_Cond_IN, in, 1, branch condition flag from the datapath.
- CSAD_Stall_IN, in, 1, freeze request.
- CSAD_Direccion_OUT, out, W, current micro-address (registered).
- CSAD_StackFull_OUT, out, 1, stack holds STACK_DEPTH entries.
- CSAD_StackEmpty_OUT, out, 1, stack holds 0 entries.
- CSAD_Error_OUT, out, 1, sticky overflow/underflow flag.

W = Direction_BUS_WIDTH.

## Operation
- **Registers:**
  - addr (W bits).
  - stack[STACK_DEPTH] (W bits each).
  - sp (count 0..STACK_DEPTH).
  - err.
- **Flags:**
  - Full = (sp == STACK_DEPTH).
  - Empty = (sp == 0).
  - Both are combinational from sp.
- **Opcodes (evaluated on each rising edge when Stall=0):**
  - 000 NEXT: addr ← INC.
  - 001 JUMP: addr ← JMP.
  - 010 BRT: addr ← Cond ? JMP : INC.
  - 011 BRF: addr ← Cond ? INC : JMP.
  - 100 CALL:
    - If not Full: stack[sp] ← INC, sp ← sp+1, addr ← JMP.
    - If Full: no push, sp unchanged, addr ← INC, err ← 1.
  - 101 RET:
    - If not Empty: addr ← stack[sp-1], sp ← sp-1.
    - If Empty: addr ← INC, sp unchanged, err ← 1.
  - 110 RESTART: addr ← 0, sp ← 0; stack contents are don't-care; err unchanged.
  - 111 HOLD: addr unchanged, sp unchanged.
- **Stall=1:** addr, sp, stack and err all hold, whatever Op is. Stall has priority over every opcode.
- **err:** sticky; cleared only by reset.
- **Arithmetic:** the block performs no addition. Wrap of INC (all-ones + 1 → 0) is the incrementer's responsibility and is passed through unchanged. sp is ceil(log2(STACK_DEPTH))+1 bits wide and never exceeds STACK_DEPTH.

## Timing
- **Reset:** asynchronous assert. While CSAD_RESET_InHigh=1:
  - Direccion_OUT = 0.
  - sp = 0, so StackEmpty=1 and StackFull=0.
  - Error = 0.
- **Reset release:** first update on the first rising edge after deassertion.
- **Reset mid-operation:** the stack is discarded and addr returns to 0 regardless of Op or Stall.
- **Latency:** one cycle. Inputs sampled at rising edge k determine Direccion_OUT after edge k.
- **Incrementer handshake:**
  - The incrementer registers on the falling edge, so INC for address A is valid from the falling edge of the cycle in which Direccion_OUT=A.
  - INC_IN must therefore be stable before the next rising edge. No other handshake exists.
- **Flag timing:** Full, Empty and Error reflect the post-edge state in the same cycle as the new Direccion_OUT.
- **CALL at Full / RET at Empty:** handled as defined in Operation. The stack is never corrupted and there is no wrap of sp.
- **Back-to-back CALL/RET:** allowed every cycle. A RET immediately after a CALL returns the address pushed by that CALL.

## Test plan
- Reset asserted mid-run with addr=0x155, sp=2 → Direccion_OUT=0, Empty=1, Full=0, Error=0 immediately (no clock edge needed).
- NEXT with INC=0x001, then 0x002, then 0x7FF followed by INC=0x000 → Direccion_OUT follows 0x001, 0x002, 0x7FF, 0x000 one cycle later each.
- BRT with Cond=1, JMP=0x040 → 0x040. BRF with Cond=1, INC=0x041 → 0x041. BRF with Cond=0, JMP=0x100 → 0x100.
- Nested CALLs:
  - CALL×4 (JMP=0x100/0x200/0x300/0x400, INC=0x011/0x101/0x201/0x301) → Full=1 after the fourth.
  - A fifth CALL (INC=0x401) → Error=1, addr=0x401, sp stays 4.
  - RET×4 → addresses 0x301, 0x201, 0x101, 0x011, then Empty=1.
- RET with Empty=1 and INC=0x022 → addr=0x022, Error=1. Error stays 1 through later NEXT and RESTART, and clears only on reset.
- Stall=1 held 3 cycles during CALL → addr, sp, flags unchanged. On Stall=0 the CALL executes exactly once. HOLD with Stall=0 also leaves addr unchanged.
